// File: rtl/fetch_top.sv
// Instruction fetch stage: PC register, PC+4 / redirect selection and the
// fetch-to-decode pipeline register with stall and flush control.
// Optional performance counters are built only when the macro
// FETCH_PERF_COUNT_EN is defined; otherwise both counters read constant 0.
module fetch_top #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             PCSrcE,
  input  logic [WIDTH-1:0] PCTargetE,
  input  logic [31:0]      InstrF,
  output logic [WIDTH-1:0] PCF,
  output logic [31:0]      InstrD,
  output logic [WIDTH-1:0] PCD,
  output logic [WIDTH-1:0] PCPlus4D,
  output logic             ValidD,
  output logic [31:0]      FetchCount,
  output logic [31:0]      RedirectCount
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_plus4_f;
  logic [WIDTH-1:0] pc_next;
  logic [31:0]      instr_dec_q, instr_dec_d;
  logic [WIDTH-1:0] pc_dec_q, pc_dec_d;
  logic [WIDTH-1:0] pc4_dec_q, pc4_dec_d;
  logic             valid_dec_q, valid_dec_d;
  logic             dec_load;

  assign pc_plus4_f = pc_q + WIDTH'(4);
  assign pc_next    = PCSrcE ? PCTargetE : pc_plus4_f;
  // A decode load (not flushed, not stalled) is what the fetch counter counts.
  assign dec_load   = !FlushD && !StallD;

  // Next PC: a redirect beats StallF; the target is forced word-aligned.
  always_comb begin
    pc_d = pc_q;
    if (PCSrcE || !StallF) begin
      pc_d = pc_next & ~WIDTH'(3);
    end
  end

  // Next decode-register contents: flush beats stall, stall holds.
  always_comb begin
    instr_dec_d = instr_dec_q;
    pc_dec_d    = pc_dec_q;
    pc4_dec_d   = pc4_dec_q;
    valid_dec_d = valid_dec_q;
    if (FlushD) begin
      instr_dec_d = NOP_INSTR;
      pc_dec_d    = '0;
      pc4_dec_d   = '0;
      valid_dec_d = 1'b0;
    end else if (!StallD) begin
      instr_dec_d = InstrF;
      pc_dec_d    = pc_q;
      pc4_dec_d   = pc_plus4_f;
      valid_dec_d = 1'b1;
    end
  end

  // PC and decode register; reset drops any pending redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      instr_dec_q <= NOP_INSTR;
      pc_dec_q    <= '0;
      pc4_dec_q   <= '0;
      valid_dec_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_dec_q <= instr_dec_d;
      pc_dec_q    <= pc_dec_d;
      pc4_dec_q   <= pc4_dec_d;
      valid_dec_q <= valid_dec_d;
    end
  end

  assign PCF      = pc_q;
  assign InstrD   = instr_dec_q;
  assign PCD      = pc_dec_q;
  assign PCPlus4D = pc4_dec_q;
  assign ValidD   = valid_dec_q;

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] redir_cnt_q;

  // Saturating event counters for decode loads and redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (dec_load && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (PCSrcE && (redir_cnt_q != 32'hFFFF_FFFF)) begin
        redir_cnt_q <= redir_cnt_q + 32'd1;
      end
    end
  end

  assign FetchCount    = fetch_cnt_q;
  assign RedirectCount = redir_cnt_q;
`else
  logic unused_dec_load;
  assign unused_dec_load = dec_load;
  assign FetchCount      = '0;
  assign RedirectCount   = '0;
`endif

endmodule

// File: tb/tb_fetch_top.sv
// Self-checking bench for fetch_top: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model of the fetch stage.
module tb_fetch_top;

`ifdef FETCH_PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D, FetchCount, RedirectCount;
  logic        ValidD;

  logic [31:0] InstrF_w, PCF_w, InstrD_w, PCD_w, PCPlus4D_w, FetchCount_w, RedirectCount_w;
  logic        ValidD_w;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_fc, m_rc;
  logic        m_valid;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[17:2] ^ 16'h5A3C, ~a[17:2]};
  endfunction

  assign InstrF   = imem(PCF);
  assign InstrF_w = imem(PCF_w);

  fetch_top dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF), .PCF(PCF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .FetchCount(FetchCount), .RedirectCount(RedirectCount)
  );

  fetch_top #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF_w), .PCF(PCF_w),
    .InstrD(InstrD_w), .PCD(PCD_w), .PCPlus4D(PCPlus4D_w), .ValidD(ValidD_w),
    .FetchCount(FetchCount_w), .RedirectCount(RedirectCount_w)
  );

  task automatic drive(input logic r, input logic sf, input logic sd, input logic fd,
                       input logic ps, input logic [31:0] tgt);
    rst = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
  endtask

  // Advance model by one clock using the currently driven inputs, then clock DUT.
  task automatic step();
    logic [31:0] seq;
    if (rst) begin
      m_pc = 32'h0; m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_valid = 0; m_fc = 0; m_rc = 0;
    end else begin
      seq = m_pc + 32'd4;
      if (FlushD) begin
        m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_valid = 0;
      end else if (!StallD) begin
        m_instr = imem(m_pc); m_pcd = m_pc; m_pc4d = seq; m_valid = 1;
        if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      end
      if (PCSrcE) begin
        m_pc = (PCTargetE / 4) * 4;
        if (m_rc != 32'hFFFF_FFFF) m_rc = m_rc + 1;
      end else if (!StallF) begin
        m_pc = seq;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    // Reset during a stall with a pending redirect must discard the target.
    drive(1, 1, 1, 0, 1, 32'h80);
    step();
    n_vec++; if (PCF !== 32'h0) begin n_err++; $display("FAIL reset_pcf got=%h exp=%h", PCF, 32'h0); end
    n_vec++; if (InstrD !== NOP) begin n_err++; $display("FAIL reset_instrd got=%h exp=%h", InstrD, NOP); end
    n_vec++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin n_err++; $display("FAIL reset_pcd got=%h/%h exp=0/0", PCD, PCPlus4D); end
    n_vec++; if (ValidD !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", ValidD); end
    n_vec++; if (FetchCount !== 32'h0 || RedirectCount !== 32'h0) begin n_err++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", FetchCount, RedirectCount); end
    n_vec++; if (PCF_w !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL reset_pcf_wrap got=%h exp=fffffffc", PCF_w); end
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (PCF !== exp_pc[i]) begin n_err++; $display("FAIL free_pcf[%0d] got=%h exp=%h", i, PCF, exp_pc[i]); end
      n_vec++; if (InstrD !== imem(exp_pc[i] - 4) || PCD !== exp_pc[i] - 4 || ValidD !== 1'b1) begin
        n_err++; $display("FAIL free_dec[%0d] got=%h/%h/%b exp=%h/%h/1", i, InstrD, PCD, ValidD, imem(exp_pc[i] - 4), exp_pc[i] - 4);
      end
    end
    n_vec++; if (FetchCount !== (PERF ? 32'd3 : 32'd0)) begin n_err++; $display("FAIL free_fetchcount got=%0d exp=%0d", FetchCount, PERF ? 3 : 0); end
  endtask

  task automatic test_wrap();
    do_reset();
    step();
    n_vec++; if (PCF_w !== 32'h0) begin n_err++; $display("FAIL wrap_pcf got=%h exp=0", PCF_w); end
    n_vec++; if (PCD_w !== 32'hFFFF_FFFC || PCPlus4D_w !== 32'h0) begin n_err++; $display("FAIL wrap_dec got=%h/%h exp=fffffffc/0", PCD_w, PCPlus4D_w); end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) step();
    n_vec++; if (PCF !== 32'h10) begin n_err++; $display("FAIL redir_setup got=%h exp=10", PCF); end
    drive(0, 0, 0, 1, 1, 32'h40);
    step();
    n_vec++; if (PCF !== 32'h40) begin n_err++; $display("FAIL redir_pcf got=%h exp=40", PCF); end
    n_vec++; if (InstrD !== NOP || ValidD !== 1'b0) begin n_err++; $display("FAIL redir_flush got=%h/%b exp=%h/0", InstrD, ValidD, NOP); end
    n_vec++; if (RedirectCount !== (PERF ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL redir_count got=%0d exp=%0d", RedirectCount, PERF ? 1 : 0); end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stall();
    logic [31:0] hold_instr, hold_pcd;
    do_reset();
    for (int i = 0; i < 8; i++) step();
    hold_instr = m_instr; hold_pcd = m_pcd;
    drive(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++; if (PCF !== 32'h20) begin n_err++; $display("FAIL stall_pcf[%0d] got=%h exp=20", i, PCF); end
      n_vec++; if (InstrD !== hold_instr || PCD !== hold_pcd) begin n_err++; $display("FAIL stall_dec[%0d] got=%h/%h exp=%h/%h", i, InstrD, PCD, hold_instr, hold_pcd); end
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    n_vec++; if (PCF !== 32'h24) begin n_err++; $display("FAIL stall_release_pcf got=%h exp=24", PCF); end
    n_vec++; if (InstrD !== imem(32'h20) || PCD !== 32'h20) begin n_err++; $display("FAIL stall_release_dec got=%h/%h exp=%h/20", InstrD, PCD, imem(32'h20)); end
  endtask

  task automatic test_stall_redirect();
    do_reset();
    step();
    drive(0, 1, 0, 0, 1, 32'h103);
    step();
    n_vec++; if (PCF !== 32'h100) begin n_err++; $display("FAIL stallredir_pcf got=%h exp=100", PCF); end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) step();
    drive(0, 1, 1, 0, 0, 0);
    step();
    drive(1, 1, 1, 0, 1, 32'h80);
    step();
    n_vec++; if (PCF !== 32'h0 || ValidD !== 1'b0 || InstrD !== NOP) begin n_err++; $display("FAIL rstmid_state got=%h/%b/%h exp=0/0/%h", PCF, ValidD, InstrD, NOP); end
    n_vec++; if (FetchCount !== 32'h0 || RedirectCount !== 32'h0) begin n_err++; $display("FAIL rstmid_counters got=%0d/%0d exp=0/0", FetchCount, RedirectCount); end
    drive(0, 0, 0, 0, 0, 0);
    step();
    n_vec++; if (PCD !== 32'h0 || InstrD !== imem(32'h0) || PCF !== 32'h4) begin n_err++; $display("FAIL rstmid_first got=%h/%h/%h exp=0/%h/4", PCD, InstrD, PCF, imem(32'h0)); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom);
      step();
      n_vec++; if (PCF !== m_pc) begin n_err++; $display("FAIL rnd_pcf[%0d] got=%h exp=%h", i, PCF, m_pc); end
      n_vec++; if (InstrD !== m_instr) begin n_err++; $display("FAIL rnd_instrd[%0d] got=%h exp=%h", i, InstrD, m_instr); end
      n_vec++; if (PCD !== m_pcd || PCPlus4D !== m_pc4d) begin n_err++; $display("FAIL rnd_pcd[%0d] got=%h/%h exp=%h/%h", i, PCD, PCPlus4D, m_pcd, m_pc4d); end
      n_vec++; if (ValidD !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, ValidD, m_valid); end
      n_vec++; if (FetchCount !== (PERF ? m_fc : 32'd0) || RedirectCount !== (PERF ? m_rc : 32'd0)) begin
        n_err++; $display("FAIL rnd_counters[%0d] got=%0d/%0d exp=%0d/%0d", i, FetchCount, RedirectCount, PERF ? m_fc : 0, PERF ? m_rc : 0);
      end
    end
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    m_pc = 0; m_instr = NOP; m_pcd = 0; m_pc4d = 0; m_valid = 0; m_fc = 0; m_rc = 0;
    @(negedge clk);
    test_reset();
    test_free_run();
    test_wrap();
    test_redirect();
    test_stall();
    test_stall_redirect();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_top.md
FETCH_TOP -- requirements
Module: fetch_top

Interface
REQ-001 Parameter WIDTH, 32, datapath and PC width.
REQ-002 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter NOP_INSTR, 32'h0000_0013, instruction word (addi x0,x0,0) inserted on flush.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 StallF  in  1  hold PCF.
REQ-008 StallD  in  1  hold fetch-to-decode register.
REQ-009 FlushD  in  1  bubble fetch-to-decode register.
REQ-010 PCSrcE  in  1  redirect request from Execute.
REQ-011 PCTargetE  in  WIDTH  redirect target from Execute.
REQ-012 InstrF  in  32  instruction memory read data for PCF, combinational.
REQ-013 PCF  out  WIDTH  current fetch address to instruction memory.
REQ-014 InstrD, PCD, PCPlus4D  out  32/WIDTH/WIDTH  decode-stage instruction, its PC, and its PC+4.
REQ-015 ValidD  out  1  InstrD holds a real fetched instruction.
REQ-016 FetchCount, RedirectCount  out  32 each  performance counters (REQ-031).

Function
REQ-017 PCPlus4F SHALL be PCF+4 modulo 2^WIDTH; 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-018 PCNext SHALL be PCTargetE when PCSrcE=1, else PCPlus4F.
REQ-019 PCF SHALL load PCNext each cycle unless StallF=1 and PCSrcE=0; PCSrcE=1 overrides StallF.
REQ-020 PCNext bits [1:0] SHALL be forced to 00 before PCF is loaded.
REQ-021 When FlushD=0 and StallD=0, the decode register SHALL load InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=1.
REQ-022 When StallD=1 and FlushD=0, all decode-register outputs SHALL hold.
REQ-023 When FlushD=1, the decode register SHALL load InstrD<=NOP_INSTR, PCD<=0, PCPlus4D<=0, ValidD<=0; FlushD overrides StallD.
REQ-024 Latency: the instruction at PCF in cycle n SHALL appear on InstrD in cycle n+1 when it is not stalled or flushed.
REQ-025 A redirect SHALL make PCF=PCTargetE in the cycle after PCSrcE=1; the wrong-path fetch is removed only by FlushD.
REQ-026 Simultaneous StallF=1, StallD=1, PCSrcE=0 SHALL freeze PCF and the decode register together, so no instruction is lost or duplicated.

Reset
REQ-027 rst=1 SHALL override every other input on that edge.
REQ-028 Reset values: PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, FetchCount=0, RedirectCount=0.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard the pending PCTargetE; the first post-reset fetch SHALL be at RESET_PC.

Configuration
REQ-030 Macro FETCH_PERF_COUNT_EN SHALL control the performance counters.
REQ-031 Defined: FetchCount SHALL increment on each edge where REQ-021 applies; RedirectCount SHALL increment on each edge with PCSrcE=1 and rst=0; both SHALL saturate at 32'hFFFF_FFFF.
REQ-032 Undefined: FetchCount and RedirectCount SHALL be constant 0, no counter flops SHALL be synthesized, and all other behaviour SHALL be identical.

Verification
REQ-033 Reset, then 3 free-running cycles -> PCF = 0, 4, 8, 0xC; InstrD lags PCF by one cycle; ValidD=1 from the second cycle.
REQ-034 PCF=0x10 with PCSrcE=1, PCTargetE=0x40, FlushD=1 -> next cycle PCF=0x40, InstrD=0x0000_0013, ValidD=0, and RedirectCount=1 when the macro is defined.
REQ-035 StallF=StallD=1 for 2 cycles at PCF=0x20 -> PCF stays 0x20 and InstrD/PCD stay constant; on release PCF=0x24.
REQ-036 StallF=1 with PCSrcE=1, PCTargetE=0x103 -> PCF=0x100, since redirect wins and the low bits are cleared.
REQ-037 RESET_PC=0xFFFF_FFFC, no stalls -> the next PCF is 0x0000_0000.
REQ-038 rst=1 asserted during a stall with PCSrcE=1, PCTargetE=0x80 -> PCF=RESET_PC, all outputs take their REQ-028 values, and counters read 0.
